// File: rtl/ps2_pkg.sv
// ps2_pkg: scan-code constants, key kinds, prefix FSM states and make-code decode.
package ps2_pkg;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_0     = 8'h45;
  localparam logic [7:0] SC_1     = 8'h16;
  localparam logic [7:0] SC_2     = 8'h1E;
  localparam logic [7:0] SC_3     = 8'h26;
  localparam logic [7:0] SC_4     = 8'h25;
  localparam logic [7:0] SC_5     = 8'h2E;
  localparam logic [7:0] SC_6     = 8'h36;
  localparam logic [7:0] SC_7     = 8'h3D;
  localparam logic [7:0] SC_8     = 8'h3E;
  localparam logic [7:0] SC_9     = 8'h46;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_B     = 8'h32;
  localparam logic [7:0] SC_C     = 8'h21;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_E     = 8'h24;
  localparam logic [7:0] SC_F     = 8'h2B;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [1:0] KIND_HEX   = 2'b00;
  localparam logic [1:0] KIND_ENTER = 2'b01;
  localparam logic [1:0] KIND_BKSP  = 2'b10;
  localparam logic [1:0] KIND_ESC   = 2'b11;
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_BREAK     = 2'd1;
  localparam logic [1:0] ST_EXT       = 2'd2;
  localparam logic [1:0] ST_EXT_BREAK = 2'd3;
  typedef struct packed {
    logic       vld;
    logic [1:0] kind;
    logic [3:0] code;
  } dec_t;
  function automatic dec_t decode(input logic [7:0] b, input logic ext);
    dec_t d;
    d = '{vld: 1'b1, kind: KIND_HEX, code: 4'h0};
    if (ext) begin
      d.vld = b == SC_ENTER;
      d.kind = KIND_ENTER;
    end else begin
      case (b)
        SC_0: d.code = 4'h0;
        SC_1: d.code = 4'h1;
        SC_2: d.code = 4'h2;
        SC_3: d.code = 4'h3;
        SC_4: d.code = 4'h4;
        SC_5: d.code = 4'h5;
        SC_6: d.code = 4'h6;
        SC_7: d.code = 4'h7;
        SC_8: d.code = 4'h8;
        SC_9: d.code = 4'h9;
        SC_A: d.code = 4'hA;
        SC_B: d.code = 4'hB;
        SC_C: d.code = 4'hC;
        SC_D: d.code = 4'hD;
        SC_E: d.code = 4'hE;
        SC_F: d.code = 4'hF;
        SC_ENTER: d.kind = KIND_ENTER;
        SC_BKSP: d.kind = KIND_BKSP;
        SC_ESC: d.kind = KIND_ESC;
        default: d.vld = 1'b0;
      endcase
    end
    return d;
  endfunction
endpackage

// File: rtl/key_fifo.sv
// key_fifo: DEPTH x WIDTH event buffer; a push on full is accepted only alongside a pop.
module key_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             drop
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic full, pop, do_push;
  assign valid = count != '0;
  assign full = count == (AW+1)'(DEPTH);
  assign pop = valid && ready;
  assign do_push = push && (!full || pop);
  assign drop = push && full && !pop;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) mem[wr_ptr] <= din;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, pop};
    end
  end
endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 set-2 bytes -> buffered key events; PS2_TYPEMATIC_FILTER_EN drops auto-repeat makes.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ps2_data,
  input  logic       ps2_new_data,
  output logic [3:0] key_code,
  output logic [1:0] key_kind,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       overflow
);
  logic [1:0] state, state_nx;
  logic is_make, ext, rep, push, drop;
  dec_t d;
  logic [5:0] head;
  assign ext = state == ST_EXT;
  assign is_make = ps2_new_data && ps2_data != SC_BREAK && (ext || (state == ST_IDLE && ps2_data != SC_EXT));
  assign d = decode(ps2_data, ext);
  assign push = is_make && d.vld && !rep;
  always_comb begin
    state_nx = state;
    if (ps2_new_data)
      state_nx = state == ST_IDLE ? (ps2_data == SC_BREAK ? ST_BREAK : ps2_data == SC_EXT ? ST_EXT : ST_IDLE) :
                 ext && ps2_data == SC_BREAK ? ST_EXT_BREAK : ST_IDLE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      if (drop) overflow <= 1'b1;
    end
  end
`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [7:0] last_code;
  logic last_ext, last_vld, is_break;
  assign is_break = ps2_new_data && (state == ST_BREAK || state == ST_EXT_BREAK);
  assign rep = last_vld && last_code == ps2_data && last_ext == ext;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_code <= '0;
      last_ext <= 1'b0;
      last_vld <= 1'b0;
    end else if (is_break) begin
      if (last_code == ps2_data && last_ext == (state == ST_EXT_BREAK)) last_vld <= 1'b0;
    end else if (is_make) begin
      last_code <= ps2_data;
      last_ext <= ext;
      last_vld <= 1'b1;
    end
  end
`else
  assign rep = 1'b0;
`endif
  key_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(6)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .din({d.kind, d.code}),
    .ready(key_ready),
    .dout(head),
    .valid(key_valid),
    .drop(drop)
  );
  assign key_kind = head[5:4];
  assign key_code = head[3:0];
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: scoreboard bench; expected {kind,code} queued at stimulus, compared on drain.
module tb_ps2_key_decoder;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [7:0] ps2_data = 8'h00;
  logic ps2_new_data = 1'b0;
  logic key_ready = 1'b0;
  logic [3:0] key_code;
  logic [1:0] key_kind;
  logic key_valid, overflow;
  logic [5:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ps2_key_decoder #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .ps2_data(ps2_data), .ps2_new_data(ps2_new_data),
    .key_code(key_code), .key_kind(key_kind), .key_valid(key_valid),
    .key_ready(key_ready), .overflow(overflow)
  );

  task automatic send(input logic [7:0] b);
    ps2_data = b;
    ps2_new_data = 1'b1;
    @(negedge clk);
    ps2_new_data = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    logic [5:0] e;
    key_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (key_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s: unexpected event kind=%b code=%h, none required", name, key_kind, key_code);
        end else begin
          e = exp_q.pop_front();
          if ({key_kind, key_code} !== e) begin
            errors++;
            $display("FAIL %s: got kind=%b code=%h, required kind=%b code=%h", name, key_kind, key_code, e[5:4], e[3:0]);
          end
        end
      end
      @(negedge clk);
    end
    key_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d events missing, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({key_valid, key_kind, key_code, overflow} !== 8'h00) begin
      errors++;
      $display("FAIL reset: valid=%b kind=%b code=%h ovf=%b, required all 0", key_valid, key_kind, key_code, overflow);
    end
  endtask

  task automatic test_single_backpressure();
    send(8'h16);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({key_valid, key_kind, key_code} !== 7'b1_00_0001) begin
        errors++;
        $display("FAIL single_hold%0d: valid=%b kind=%b code=%h, required 1/00/1", i, key_valid, key_kind, key_code);
      end
      @(negedge clk);
    end
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    checks++;
    if (key_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pop: valid=%b, required 0", key_valid);
    end
  endtask

  task automatic test_break();
    send(8'h1C); exp_q.push_back(6'h0A);
    send(8'hF0);
    send(8'h1C);
    send(8'h66); exp_q.push_back(6'h20);
    send(8'h76); exp_q.push_back(6'h30);
    drain("break");
  endtask

  task automatic test_extended();
    send(8'hE0); send(8'h5A); exp_q.push_back(6'h10);
    send(8'hE0); send(8'hF0); send(8'h5A);
    send(8'hE0); send(8'h75);
    send(8'h2B); exp_q.push_back(6'h0F);
    drain("extended");
  endtask

  task automatic test_overflow();
    logic [7:0] mk [5] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25};
    for (int i = 0; i < 5; i++) begin
      send(mk[i]);
      if (i < 4) exp_q.push_back(6'(i));
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set: overflow=%b, required 1", overflow);
    end
    drain("overflow_drain");
  endtask

  task automatic test_full_push_pop();
    logic [7:0] mk [4] = '{8'h45, 8'h16, 8'h1E, 8'h26};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(mk[i]);
      exp_q.push_back(6'(i));
    end
    checks++;
    if (key_code !== 4'h0) begin
      errors++;
      $display("FAIL full_head: code=%h, required 0", key_code);
    end
    void'(exp_q.pop_front());
    key_ready = 1'b1;
    send(8'h25); exp_q.push_back(6'h04);
    key_ready = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_push_pop_ovf: overflow=%b, required 0", overflow);
    end
    drain("full_push_pop");
  endtask

  task automatic test_typematic();
    send(8'h16); exp_q.push_back(6'h01);
    send(8'h16);
`ifndef PS2_TYPEMATIC_FILTER_EN
    exp_q.push_back(6'h01);
`endif
    send(8'h16);
`ifndef PS2_TYPEMATIC_FILTER_EN
    exp_q.push_back(6'h01);
`endif
    send(8'hF0); send(8'h16);
    send(8'h16); exp_q.push_back(6'h01);
    drain("typematic");
  endtask

  task automatic test_reset_mid();
    send(8'h16);
    send(8'hF0);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({key_valid, key_kind, key_code} !== 7'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: valid=%b kind=%b code=%h ovf=%b, required all 0", key_valid, key_kind, key_code, overflow);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send(8'h16); exp_q.push_back(6'h01);
    drain("reset_mid_restart");
  endtask

  initial begin
    test_reset();
    test_single_backpressure();
    test_break();
    test_extended();
    test_typematic();
    test_overflow();
    test_full_push_pop();
    test_overflow();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Converts the raw PS/2 scan-code byte stream (set 2) into decoded key events for the lock logic and the display. It sits directly downstream of the debounced PS/2 receive strobe and upstream of the protector and display stages. It strips break (F0) and extended (E0) prefixes and maps make codes to hex digits or control keys. Each event is buffered in a small FIFO with a valid/ready handshake.

## Interface
- `FIFO_DEPTH`, default 4: key-event buffer depth; power of two, ≥2.
- `clk`  in  1  system clock.
- `reset`  in  1  reset. One clock; reset is asynchronous and active-low.
- `ps2_data`  in  8  received scan-code byte; valid when `ps2_new_data`=1.
- `ps2_new_data`  in  1  one-cycle strobe per received byte, synchronous to `clk`.
- `key_code`  out  4  hex value of the head event (0 for control keys).
- `key_kind`  out  2  head event class: 00 hex digit, 01 enter, 10 backspace, 11 escape.
- `key_valid`  out  1  FIFO non-empty; the head event is presented.
- `key_ready`  in  1  consumer accepts the head event when `key_valid`=1.
- `overflow`  out  1  sticky flag: an event was dropped on a full FIFO.

## Operation
- **Make-code map**, hex digits:
  - 45→0, 16→1, 1E→2, 26→3, 25→4, 2E→5, 36→6, 3D→7, 3E→8, 46→9.
  - 1C→A, 32→B, 21→C, 23→D, 24→E, 2B→F.
- **Make-code map**, control keys: 5A→enter, 66→backspace, 76→escape.
- **Extended codes:** E0 5A→enter. All other extended codes and unmapped codes are discarded silently.
- **Prefix FSM**, one transition per strobe:
  - IDLE: F0→BREAK; E0→EXT; any other byte→decode as make, stay IDLE.
  - BREAK: any byte is the released key; no event; →IDLE.
  - EXT: F0→EXT_BREAK; any other byte→decode as extended make; →IDLE.
  - EXT_BREAK: any byte; no event; →IDLE.
- **Push:** each decoded event is pushed as {kind, code}.
- **Full FIFO:** a push while full, with no pop in the same cycle, drops the new event and sets `overflow`. Existing contents and their order are preserved.
- **Pop:** occurs when `key_valid` && `key_ready`.
- **Simultaneous push and pop:**
  - On a full FIFO, both are accepted and no overflow is raised.
  - On an empty FIFO, the push is accepted and no pop occurs.
- **Pointers:** wrap modulo `FIFO_DEPTH`. Occupancy counter width is log2(FIFO_DEPTH)+1.
- **Overflow clear:** `overflow` clears only on reset.

## Timing
- **Reset values:**
  - `key_valid`=0, `key_code`=0, `key_kind`=00, `overflow`=0.
  - FSM in IDLE, FIFO empty.
- **Asynchronous reset:** asserting reset mid-sequence (e.g. after F0) discards the prefix state immediately.
- **Latency:** strobe in cycle N with an empty FIFO → `key_valid`=1 and outputs valid from cycle N+1.
- **Pop update:** the head updates in the cycle after a pop.
- **Output stability:** outputs come straight from registers/FIFO storage and hold stable while `key_valid`=1 and `key_ready`=0.
- **Throughput:** one byte per cycle; back-to-back strobes are legal.

## Configuration
- **`PS2_TYPEMATIC_FILTER_EN` defined:**
  - A `last_make` register (8 bits plus an ext flag, valid bit) suppresses auto-repeat.
  - A make identical to `last_make` with no intervening break produces no event.
  - A break of that key clears `last_make`.
  - A different make replaces it.
  - Reset clears it.
- **`PS2_TYPEMATIC_FILTER_EN` undefined:** every make, repeats included, produces an event.

## Structure
- **Shared package `ps2_pkg`:**
  - scan-code constants (F0, E0, the mapped make codes);
  - `key_kind` encoding;
  - prefix FSM state encoding.
- **Sub-module `key_fifo`:**
  - parameterised by depth and width;
  - push/pop, full/empty flags, same-cycle push/pop rule;
  - decoder drives its push side.

## Test plan
- **Single key with backpressure:** byte 16 strobe with `key_ready`=0 → from next cycle `key_valid`=1, `key_code`=1, `key_kind`=00. Outputs held while ready is low. `key_ready`=1 for one cycle → `key_valid`=0.
- **Break suppression:** sequence 1C, F0, 1C → exactly one event (code A). The released byte 1C after F0 produces nothing.
- **Extended keys:** E0 5A, E0 F0 5A, E0 75 → exactly one event, `key_kind`=01. Other extended codes ignored.
- **Overflow:** `FIFO_DEPTH`=4, `key_ready`=0, makes 45, 16, 1E, 26, 25 → `overflow`=1. Draining yields 0, 1, 2, 3; key 4 is lost. A full FIFO with pop and push in the same cycle raises no overflow.
- **Typematic filter:** 16, 16, 16, F0 16, 16 → two events with `PS2_TYPEMATIC_FILTER_EN`; four events without it.
- **Reset mid-sequence:** reset asserted after F0 → all outputs at reset values. After release, byte 16 → one event (code 1), proving the FSM restarted in IDLE.
